cycle_sequencer: RTL

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer_pkg.sv | 13 +
 rtl/cycle_sequencer_if.sv | 33 +++
 rtl/cycle_sequencer_onehot_ring.sv | 34 +++
 rtl/cycle_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the M-cycle / T-state sequencer: state encoding
// and default geometry (T-states per M-cycle, M-cycles per instruction).
package cycle_sequencer_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

  localparam int DEF_N_STEPS    = 4;
  localparam int DEF_N_MCYCLES  = 8;

endpackage

// File: rtl/cycle_sequencer_if.sv
// Control bundle between the microcode engine (master) and the cycle
// sequencer (slave). Clock and reset travel as plain ports.
interface cycle_sequencer_if
  import cycle_sequencer_pkg::*;
#(
  parameter int N_STEPS   = DEF_N_STEPS,
  parameter int N_MCYCLES = DEF_N_MCYCLES
) ();

  logic                 i_IR_Fetch;
  logic                 i_Stall;
  logic                 i_Halt_Req;
  logic                 i_Wake;
  logic [N_STEPS-1:0]   o_Cycle_Step;
  logic [N_MCYCLES-1:0] o_Cycle_Count;
  logic                 o_Active;
  logic                 o_Instr_Start;
  logic                 o_Halted;
  logic                 o_Seq_Error;

  modport master (
    output i_IR_Fetch, i_Stall, i_Halt_Req, i_Wake,
    input  o_Cycle_Step, o_Cycle_Count, o_Active, o_Instr_Start,
           o_Halted, o_Seq_Error
  );

  modport slave (
    input  i_IR_Fetch, i_Stall, i_Halt_Req, i_Wake,
    output o_Cycle_Step, o_Cycle_Count, o_Active, o_Instr_Start,
           o_Halted, o_Seq_Error
  );

endinterface

// File: rtl/cycle_sequencer_onehot_ring.sv
// One-hot rotating ring register. Load forces bit0 and wins over advance;
// advance rotates one position left with the top bit wrapping to bit0.
module onehot_ring #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             load_bit0_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] q_o
);

  localparam logic [WIDTH-1:0] BIT0 = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next ring value: load to bit0, rotate, or hold.
  always_comb begin
    q_d = q_q;
    if (load_bit0_i) begin
      q_d = BIT0;
    end else if (advance_i) begin
      q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    end
  end

  // Ring storage.
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle sequencer for a microcoded CPU. Tracks the current
// T-state and M-cycle as one-hot rings, handles HALT entry/exit, flags
// M-cycle overflow, and pulses Instr_Start at T1 of every new instruction.
// Every output is taken straight from a register; inputs sampled at a clock
// edge shape the outputs of the cycle that follows that edge.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int N_STEPS   = DEF_N_STEPS,
  parameter int N_MCYCLES = DEF_N_MCYCLES
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  cycle_sequencer_if.slave   bus
);

  localparam logic [0:0] S_RUN  = ST_RUN;
  localparam logic [0:0] S_HALT = ST_HALT;

  logic [N_STEPS-1:0]   step;
  logic [N_MCYCLES-1:0] count;

  logic [0:0] state_q,   state_d;
  logic       pending_q, pending_d;   // first fetch after reset not yet issued
  logic       start_q,   start_d;
  logic       active_q,  active_d;
  logic       err_q,     err_d;

  logic boundary;
  logic count_last;
  logic step_adv;
  logic cnt_load;
  logic cnt_adv;

  // Boundary = leaving the last T-state of an M-cycle on an unstalled clock.
  always_comb begin
    boundary   = step[N_STEPS-1] & ~bus.i_Stall;
    count_last = count[N_MCYCLES-1];
    // The first clock after reset re-presents T1 instead of rotating, so the
    // opening fetch gets a full T1 with Active and Instr_Start both high.
    step_adv   = ~bus.i_Stall & ~pending_q;
    cnt_load   = i_Reset
               | (boundary & ((state_q == S_HALT) | bus.i_IR_Fetch | count_last));
    cnt_adv    = boundary & (state_q == S_RUN) & ~bus.i_IR_Fetch & ~count_last;
  end

  onehot_ring #(.WIDTH(N_STEPS)) u_step_ring (
    .clk_i       (i_Clk),
    .load_bit0_i (i_Reset),
    .advance_i   (step_adv),
    .q_o         (step)
  );

  onehot_ring #(.WIDTH(N_MCYCLES)) u_count_ring (
    .clk_i       (i_Clk),
    .load_bit0_i (cnt_load),
    .advance_i   (cnt_adv),
    .q_o         (count)
  );

  // Next-state for RUN/HALT, Instr_Start pulse, overflow flag and Active.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    start_d   = 1'b0;
    err_d     = err_q;
    if (bus.i_Stall) begin
      // Frozen: everything holds, no new-instruction pulse while stalled.
      start_d = 1'b0;
    end else if (pending_q) begin
      pending_d = 1'b0;
      start_d   = 1'b1;
    end else if (boundary) begin
      if (state_q == S_RUN) begin
        if (bus.i_IR_Fetch && bus.i_Halt_Req) begin
          state_d = S_HALT;
        end else if (bus.i_IR_Fetch) begin
          start_d = 1'b1;
        end else if (count_last) begin
          // Microcode ran past the last M-cycle: recover by refetching.
          err_d   = 1'b1;
          start_d = 1'b1;
        end
      end else if (bus.i_Wake) begin
        state_d = S_RUN;
        start_d = 1'b1;
      end
    end
    active_d = ~bus.i_Stall & (state_d == S_RUN);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= S_RUN;
      pending_q <= 1'b1;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      active_q  <= active_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_Cycle_Step  = step;
  assign bus.o_Cycle_Count = count;
  assign bus.o_Active      = active_q;
  assign bus.o_Instr_Start = start_q;
  assign bus.o_Halted      = (state_q == S_HALT);
  assign bus.o_Seq_Error   = err_q;

endmodule
